// File: rtl/actor_pkg.sv
// Shared types and helpers for the dataflow actor family.
package actor_pkg;

    // Actor control states shared by sibling actors
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Output width for a sum of n tokens of data_width bits each, with no overflow
    function automatic int unsigned out_width(input int unsigned data_width,
                                              input int unsigned n);
        return data_width + $clog2(n);
    endfunction

endpackage

// File: rtl/actor_accumulate.sv
// Accumulating actor: pops N tokens from an upstream FIFO one at a time,
// sums them, and pushes the sum to a downstream FIFO.
module actor_accumulate
    import actor_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned N          = 4,
    localparam int unsigned OUT_WIDTH  = out_width(DATA_WIDTH, N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_read,
    output logic [OUT_WIDTH-1:0]  out_din,
    input  logic                  out_full,
    output logic                  out_write
);

    localparam int unsigned          CNT_WIDTH = $clog2(N);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(N - 1);

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // FIFO handshakes: decoded from the registered state so the FIFOs see the
    // request in the same cycle; in_read is gated by rst so it stays low in reset
    always_comb begin
        in_read   = rst && (state_q == S_IDLE) && !in_empty;
        out_write = (state_q == S_WRITE) && !out_full;
    end

    assign out_din = acc_q;

    // Next-state, accumulator and token counter
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_read) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                // in_dout holds the token popped on the previous edge
                acc_d   = acc_q + OUT_WIDTH'(in_dout);
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = (cnt_q == CNT_LAST) ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                if (out_write) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_actor_accumulate.sv
// Self-checking bench for actor_accumulate: directed vector table, hand-written
// corner sequences, and randomized traffic against a group-sum reference model.
module tb_actor_accumulate;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_dout_a, in_dout_b;
    logic       in_empty_a, in_empty_b;
    logic       in_read_a, in_read_b;
    logic       out_full_a, out_full_b;
    logic       out_write_a, out_write_b;
    logic [9:0] out_din_a;
    logic [8:0] out_din_b;

    actor_accumulate #(.DATA_WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst),
        .in_dout(in_dout_a), .in_empty(in_empty_a), .in_read(in_read_a),
        .out_din(out_din_a), .out_full(out_full_a), .out_write(out_write_a)
    );

    actor_accumulate #(.DATA_WIDTH(8), .N(2)) dut_n2 (
        .clk(clk), .rst(rst),
        .in_dout(in_dout_b), .in_empty(in_empty_b), .in_read(in_read_b),
        .out_din(out_din_b), .out_full(out_full_b), .out_write(out_write_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$], qb[$];     // upstream FIFO contents
    int wr_a[$], wr_b[$];         // observed output tokens
    int wcyc_a[$];                // cycle index of each write on dut
    int cyc;
    int first_pop;
    bit prev_ra, prev_rb, prev_wa, prev_wb;

    typedef struct {
        int ntok;
        int tok[8];
        int hold;
        int nexp;
        int exp[2];
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input int v);
        qa.push_back(8'(v));
        in_empty_a = 1'b0;
    endtask

    task automatic push_b(input int v);
        qb.push_back(8'(v));
        in_empty_b = 1'b0;
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic cycle();
        bit ra, rb;
        #1;
        ra = in_read_a;
        rb = in_read_b;
        if (ra) begin
            check("read_when_empty_a", in_empty_a, 0);
            check("back_to_back_pop_a", prev_ra, 0);
            if (first_pop < 0) first_pop = cyc;
        end
        if (rb) begin
            check("read_when_empty_b", in_empty_b, 0);
            check("back_to_back_pop_b", prev_rb, 0);
        end
        if (out_write_a) begin
            check("write_when_full_a", out_full_a, 0);
            check("write_pulse_a", prev_wa, 0);
            wr_a.push_back(int'(out_din_a));
            wcyc_a.push_back(cyc);
        end
        if (out_write_b) begin
            check("write_when_full_b", out_full_b, 0);
            check("write_pulse_b", prev_wb, 0);
            wr_b.push_back(int'(out_din_b));
        end
        prev_wa = out_write_a;
        prev_wb = out_write_b;
        @(negedge clk);
        cyc++;
        if (ra && qa.size() > 0) in_dout_a = qa.pop_front();
        else                     in_dout_a = 8'($urandom);
        if (rb && qb.size() > 0) in_dout_b = qb.pop_front();
        else                     in_dout_b = 8'($urandom);
        in_empty_a = (qa.size() == 0);
        in_empty_b = (qb.size() == 0);
        prev_ra = ra;
        prev_rb = rb;
    endtask

    // Reset both actors and their FIFOs (they share rst), then release.
    task automatic do_reset();
        rst = 1'b0;
        qa.delete();
        qb.delete();
        in_empty_a = 1'b0;
        in_empty_b = 1'b0;
        #1;
        check("rst_in_read_a", in_read_a, 0);
        check("rst_in_read_b", in_read_b, 0);
        check("rst_out_write_a", out_write_a, 0);
        check("rst_out_din_a", out_din_a, 0);
        check("rst_out_din_b", out_din_b, 0);
        in_empty_a = 1'b1;
        in_empty_b = 1'b1;
        out_full_a = 1'b0;
        out_full_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr_a.delete();
        wr_b.delete();
        wcyc_a.delete();
        cyc = 0;
        first_pop = -1;
        prev_ra = 0; prev_rb = 0; prev_wa = 0; prev_wb = 0;
    endtask

    task automatic wait_outputs(input int na, input int nb, input int budget);
        int k = 0;
        while ((wr_a.size() < na || wr_b.size() < nb) && k < budget) begin
            cycle();
            k++;
        end
        for (int i = 0; i < 3; i++) cycle();
    endtask

    initial begin
        int tokens[$];
        int gap_reads;
        int rel;
        int na, nb, s;

        vt[0] = '{4, '{1, 2, 3, 4, 0, 0, 0, 0},         0,  1, '{10, 0}};
        vt[1] = '{8, '{255, 255, 255, 255, 255, 255, 255, 255}, 0, 2, '{1020, 1020}};
        vt[2] = '{4, '{5, 5, 5, 5, 0, 0, 0, 0},         20, 1, '{20, 0}};
        vt[3] = '{4, '{0, 0, 0, 0, 0, 0, 0, 0},         0,  1, '{0, 0}};
        vt[4] = '{4, '{255, 0, 1, 254, 0, 0, 0, 0},     0,  1, '{510, 0}};
        vt[5] = '{8, '{1, 2, 3, 4, 10, 20, 30, 40},     0,  2, '{10, 100}};

        rst = 1'b1;
        in_dout_a = '0; in_dout_b = '0;
        in_empty_a = 1'b1; in_empty_b = 1'b1;
        out_full_a = 1'b0; out_full_b = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            out_full_a = (vt[v].hold > 0);
            for (int t = 0; t < vt[v].ntok; t++) push_a(vt[v].tok[t]);
            if (vt[v].hold > 0) begin
                for (int i = 0; i < vt[v].hold; i++) begin
                    if (i >= 8) begin
                        #1;
                        check("hold_out_din", out_din_a, vt[v].exp[0]);
                        check("hold_out_write", out_write_a, 0);
                    end
                    cycle();
                end
                out_full_a = 1'b0;
                rel = cyc;
                wait_outputs(vt[v].nexp, 0, 40);
                if (wcyc_a.size() > 0) check("write_on_release", wcyc_a[0], rel);
            end else begin
                wait_outputs(vt[v].nexp, 0, 40);
                check("first_pop_after_reset", first_pop, 0);
                if (wcyc_a.size() > 0) check("first_write_latency", wcyc_a[0], 8);
            end
            check("vec_out_count", wr_a.size(), vt[v].nexp);
            for (int k = 0; k < vt[v].nexp && k < wr_a.size(); k++)
                check("vec_out_value", wr_a[k], vt[v].exp[k]);
        end

        // Upstream runs dry mid-group: no reads in the gap, single correct sum
        do_reset();
        push_a(1); push_a(2);
        gap_reads = 0;
        for (int i = 0; i < 14; i++) begin
            if (i >= 4) begin
                #1;
                if (in_read_a) gap_reads++;
            end
            cycle();
        end
        check("gap_in_read", gap_reads, 0);
        check("gap_no_partial_out", wr_a.size(), 0);
        push_a(3); push_a(4);
        wait_outputs(1, 0, 40);
        check("gap_out_count", wr_a.size(), 1);
        if (wr_a.size() > 0) check("gap_out_value", wr_a[0], 10);

        // Reset mid-group discards the partial sum
        do_reset();
        push_a(9); push_a(9);
        for (int i = 0; i < 6; i++) cycle();
        check("partial_no_out", wr_a.size(), 0);
        #2;
        do_reset();
        push_a(1); push_a(1); push_a(1); push_a(1);
        wait_outputs(1, 0, 40);
        check("after_reset_count", wr_a.size(), 1);
        if (wr_a.size() > 0) check("after_reset_value", wr_a[0], 4);

        // N=2 build
        do_reset();
        push_b(7); push_b(8);
        wait_outputs(0, 1, 40);
        check("n2_out_count", wr_b.size(), 1);
        if (wr_b.size() > 0) check("n2_out_value", wr_b[0], 15);

        // Randomized traffic with backpressure on both actors
        do_reset();
        tokens.delete();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                s = int'($urandom_range(0, 255));
                tokens.push_back(s);
                push_a(s);
                push_b(s);
            end
            out_full_a = ($urandom_range(0, 3) == 0);
            out_full_b = ($urandom_range(0, 3) == 0);
            cycle();
        end
        while (tokens.size() % 4 != 0) begin
            s = int'($urandom_range(0, 255));
            tokens.push_back(s);
            push_a(s);
            push_b(s);
        end
        out_full_a = 1'b0;
        out_full_b = 1'b0;
        na = tokens.size() / 4;
        nb = tokens.size() / 2;
        wait_outputs(na, nb, 3000);
        check("rand_count_a", wr_a.size(), na);
        check("rand_count_b", wr_b.size(), nb);
        for (int k = 0; k < na && k < wr_a.size(); k++) begin
            s = tokens[4*k] + tokens[4*k+1] + tokens[4*k+2] + tokens[4*k+3];
            check("rand_sum_a", wr_a[k], s);
        end
        for (int k = 0; k < nb && k < wr_b.size(); k++) begin
            s = tokens[2*k] + tokens[2*k+1];
            check("rand_sum_b", wr_b[k], s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
